weight_stream_ctrl: RTL and testbench

WEIGHT_STREAM_CTRL -- requirements
Module: weight_stream_ctrl

---
 rtl/weight_stream_pkg.sv | 9 +
 rtl/weight_stream_ctrl_if.sv | 12 +
 rtl/weight_stream_fifo.sv | 34 +++
 rtl/weight_stream_ctrl.sv | 81 ++++++++
 tb/tb_weight_stream_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/weight_stream_pkg.sv
// weight_stream_pkg: shared FSM state type and parameter defaults for the weight streamer
package weight_stream_pkg;
  localparam int DATA_WIDTH_DEF   = 512;
  localparam int DEPTH_DEF        = 576;
  localparam int READ_LATENCY_DEF = 2;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int PASS_WIDTH_DEF   = 8;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/weight_stream_ctrl_if.sv
// weight_stream_ctrl_if: valid/ready output beat stream of the weight streamer
interface weight_stream_ctrl_if
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  modport master (output data_out, data_out_valid, input data_out_ready);
  modport slave (input data_out, data_out_valid, output data_out_ready);
endinterface

// File: rtl/weight_stream_fifo.sv
// weight_stream_fifo: synchronous FIFO with head-word output and occupancy count, no write-to-read bypass
module weight_stream_fifo #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 4,
  localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr, rd;
  assign rd      = rd_en && count != '0;
  assign wr      = wr_en && (count != CW'(DEPTH) || rd);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/weight_stream_ctrl.sv
// weight_stream_ctrl: sweeps a pipelined ROM num_passes times and streams words out in address order
module weight_stream_ctrl
  import weight_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int PASS_WIDTH   = PASS_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  weight_stream_ctrl_if.master  dout
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t                  state;
  logic [PASS_WIDTH-1:0]   passes_left;
  logic [READ_LATENCY-1:0] tags;
  logic [CW-1:0]           fifo_count;
  logic                    credit, issue, last_addr;
  // every in-flight read already owns a FIFO slot, so the FIFO can never overflow
  assign credit    = int'(fifo_count) + $countones(tags) < FIFO_DEPTH;
  assign issue     = state == STREAM && credit;
  assign last_addr = rom_addr == ADDR_WIDTH'(DEPTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      passes_left <= '0;
      tags        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_ce      <= 1'b0;
    end else begin
      tags <= READ_LATENCY'({tags, issue});
      case (state)
        IDLE: if (start) begin
          state       <= num_passes == '0 ? DONE : STREAM;
          passes_left <= num_passes;
          rom_addr    <= '0;
          busy        <= 1'b1;
          rom_ce      <= num_passes != '0;
          done        <= num_passes == '0;
        end
        STREAM: if (issue) begin
          rom_addr <= last_addr ? '0 : rom_addr + ADDR_WIDTH'(1);
          if (last_addr) passes_left <= passes_left - PASS_WIDTH'(1);
          if (last_addr && passes_left == PASS_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: if (tags == '0 && fifo_count == '0) begin
          state  <= DONE;
          done   <= 1'b1;
          rom_ce <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
  assign dout.data_out_valid = fifo_count != '0;
  weight_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tags[READ_LATENCY-1]),
    .wr_data (rom_q),
    .rd_en   (dout.data_out_ready),
    .rd_data (dout.data_out),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_weight_stream_ctrl.sv
// tb_weight_stream_ctrl: directed checks of the weight streamer on three lanes (read latency 2, 1 and 4)
module tb_weight_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic [7:0]  np [3];
  logic        ready [3];
  logic        busy [3], done [3], ce [3], valid [3];
  logic [3:0]  addr [3];
  logic [31:0] dout [3];
  logic [31:0] hold;
  int exp_n [3], done_n [3];
  int n_assert = 0, n_fail = 0;
  int issued, max_out, ce_seen, valid_seen;
  logic [3:0] prev_addr;
  logic       prev_ce;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [3:0] a);
    return {a, 8'h5A, ~a, 12'h3C3, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = g == 0 ? 2 : g == 1 ? 1 : 4;
    localparam int FD  = g == 2 ? 6 : 4;
    logic [3:0]  pipe [4];
    logic [31:0] q;
    weight_stream_ctrl_if #(.DATA_WIDTH(32)) sif ();
    assign sif.data_out_ready = ready[g];
    assign dout[g]  = sif.data_out;
    assign valid[g] = sif.data_out_valid;
    assign q = rom_word(pipe[LAT-1]);
    always @(posedge clk) if (ce[g]) begin
      pipe[0] <= addr[g];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    weight_stream_ctrl #(
      .DATA_WIDTH(32), .DEPTH(8), .READ_LATENCY(LAT), .FIFO_DEPTH(FD), .PASS_WIDTH(8)
    ) dut (
      .clk(clk), .rst(rst), .start(start[g]), .num_passes(np[g]), .busy(busy[g]), .done(done[g]),
      .rom_addr(addr[g]), .rom_ce(ce[g]), .rom_q(q), .dout(sif.master)
    );
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic tick();
    for (int l = 0; l < 3; l++) if (valid[l] && ready[l]) begin
      chk($sformatf("beat_lane%0d_%0d", l, exp_n[l]), dout[l], rom_word(4'(exp_n[l] % 8)));
      exp_n[l]++;
    end
    prev_addr = addr[0];
    prev_ce   = ce[0];
    @(negedge clk);
    for (int l = 0; l < 3; l++) if (done[l]) done_n[l]++;
    if (prev_ce && addr[0] != prev_addr) issued++;
    if (issued - exp_n[0] > max_out) max_out = issued - exp_n[0];
    if (ce[0]) ce_seen++;
    if (valid[0]) valid_seen++;
  endtask

  task automatic clear0();
    exp_n[0] = 0; done_n[0] = 0; issued = 0; max_out = 0; ce_seen = 0; valid_seen = 0;
  endtask

  initial begin
    rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      start[l] = 1'b0; np[l] = '0; ready[l] = 1'b1; exp_n[l] = 0; done_n[l] = 0;
    end
    clear0();
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("rst_busy%0d", l), busy[l], 0);
      chk($sformatf("rst_done%0d", l), done[l], 0);
      chk($sformatf("rst_ce%0d", l), ce[l], 0);
      chk($sformatf("rst_addr%0d", l), addr[l], 0);
      chk($sformatf("rst_valid%0d", l), valid[l], 0);
    end
    rst = 1'b0;
    tick();
    // two passes, ready high: first valid in cycle 4, 16 back-to-back beats
    clear0(); np[0] = 2; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("t1_busy", busy[0], 1);
    chk("t1_ce", ce[0], 1);
    tick(); tick();
    chk("t1_no_valid_c3", valid[0], 0);
    tick();
    chk("t1_valid_c4", valid[0], 1);
    chk("t1_first_word", dout[0], rom_word(0));
    for (int i = 0; i < 60 && done_n[0] == 0; i++) tick();
    chk("t1_beats", exp_n[0], 16);
    chk("t1_done_n", done_n[0], 1);
    chk("t1_valid_cycles", valid_seen, 16);
    tick(); tick();
    chk("t1_idle_busy", busy[0], 0);
    chk("t1_done_once", done_n[0], 1);
    // ready low for 10 cycles mid-stream, with a start pulse that must be ignored
    clear0(); np[0] = 2; start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && exp_n[0] < 5; i++) tick();
    chk("t2_reach5", exp_n[0], 5);
    ready[0] = 1'b0;
    hold = dout[0];
    chk("t2_held_word", hold, rom_word(5));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start[0] = 1'b1; np[0] = 1; end
      if (i == 4) start[0] = 1'b0;
      tick();
      chk("t2_hold_data", dout[0], hold);
      chk("t2_hold_valid", valid[0], 1);
    end
    ready[0] = 1'b1;
    for (int i = 0; i < 80 && done_n[0] == 0; i++) tick();
    chk("t2_beats", exp_n[0], 16);
    chk("t2_done_n", done_n[0], 1);
    chk("t2_max_outstanding", max_out, 4);
    repeat (3) tick();
    chk("t2_start_ignored", busy[0], 0);
    chk("t2_beats_after", exp_n[0], 16);
    // zero passes: done one cycle after start, no reads
    clear0(); np[0] = 0; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("t3_done", done[0], 1);
    chk("t3_busy", busy[0], 1);
    tick();
    chk("t3_done_low", done[0], 0);
    chk("t3_idle", busy[0], 0);
    repeat (2) tick();
    chk("t3_done_n", done_n[0], 1);
    chk("t3_ce_seen", ce_seen, 0);
    chk("t3_valid_seen", valid_seen, 0);
    // reset at beat 5 aborts without done; next job starts at address 0
    clear0(); np[0] = 2; start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 40 && exp_n[0] < 5; i++) tick();
    chk("t4_reach5", exp_n[0], 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_busy", busy[0], 0);
    chk("t4_done", done[0], 0);
    chk("t4_ce", ce[0], 0);
    chk("t4_addr", addr[0], 0);
    chk("t4_valid", valid[0], 0);
    repeat (6) tick();
    chk("t4_no_done", done_n[0], 0);
    chk("t4_stale_valid", valid[0], 0);
    clear0(); np[0] = 1; start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("t4_restart_addr", addr[0], 0);
    for (int i = 0; i < 60 && done_n[0] == 0; i++) tick();
    chk("t4_beats", exp_n[0], 8);
    chk("t4_done_n", done_n[0], 1);
    // random ready on the latency-1 and latency-4 lanes
    for (int l = 1; l < 3; l++) begin
      np[l] = 2; start[l] = 1'b1; exp_n[l] = 0; done_n[l] = 0;
    end
    tick();
    start[1] = 1'b0; start[2] = 1'b0;
    for (int i = 0; i < 400 && (done_n[1] == 0 || done_n[2] == 0); i++) begin
      ready[1] = 1'($urandom_range(0, 1));
      ready[2] = 1'($urandom_range(0, 1));
      tick();
    end
    ready[1] = 1'b1; ready[2] = 1'b1;
    chk("t5_lat1_beats", exp_n[1], 16);
    chk("t5_lat4_beats", exp_n[2], 16);
    chk("t5_lat1_done", done_n[1], 1);
    chk("t5_lat4_done", done_n[2], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
